// File: rtl/jet_tag_scheduler.sv
// jet_tag_scheduler: buffers input frames in a small FIFO and, one frame at a time,
// resets the jet-tagging core, launches it, waits for its result and hands the
// result downstream in push order together with an 8-bit sequence tag.
module jet_tag_scheduler #(
    parameter int WIDTH       = 16,
    parameter int NFRAC       = 10,
    parameter int INPUT_SIZE  = 16,
    parameter int OUTPUT_SIZE = 5,
    parameter int DEPTH       = 4,
    parameter int RST_CYCLES  = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH*INPUT_SIZE-1:0]    in_data,
    output logic                           core_reset,
    output logic                           core_input_ready,
    output logic [WIDTH*INPUT_SIZE-1:0]    core_input_data,
    input  logic                           core_output_ready,
    input  logic [WIDTH*OUTPUT_SIZE-1:0]   core_output_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH*OUTPUT_SIZE-1:0]   out_data,
    output logic [7:0]                     out_tag,
    output logic                           busy,
    output logic                           timeout_err,
    output logic [7:0]                     drop_count
);

    localparam int IN_W   = WIDTH * INPUT_SIZE;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int RST_W  = $clog2(RST_CYCLES + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    // Samples are passed through untouched, so NFRAC only has to be consistent with WIDTH.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (RST_CYCLES < 1) ||
        (TIMEOUT < 1) || (NFRAC >= WIDTH)) begin : g_param_check
        $error("jet_tag_scheduler: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CORE_RST = 3'd1,
        ST_LAUNCH   = 3'd2,
        ST_WAIT     = 3'd3,
        ST_HOLD     = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [IN_W-1:0]     fifo_data_r [DEPTH];
    logic [7:0]          fifo_tag_r  [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]    count_r, count_s;
    logic [7:0]          push_tag_r, cur_tag_r;
    logic [RST_W-1:0]    rst_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic                push_s, pop_s, out_free_s, capture_s, drop_s;

    // The full test uses the registered occupancy, so a full cycle never accepts a push
    // even when a pop happens in the same cycle.
    assign push_s     = in_valid && (count_r != CNT_W'(DEPTH));
    // Launching while an older result is still parked is safe: HOLD keeps the core's
    // result until the output register frees, so the pop only waits for data.
    assign pop_s      = (state_r == ST_IDLE) && (count_r != CNT_W'(0));
    assign out_free_s = !out_valid || out_ready;
    assign capture_s  = ((state_r == ST_WAIT) && core_output_ready && out_free_s) ||
                        ((state_r == ST_HOLD) && out_free_s);
    assign drop_s     = (state_r == ST_WAIT) && !core_output_ready &&
                        (wait_cnt_r == WAIT_W'(TIMEOUT - 1));

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        count_s = count_r;
        if (push_s && !pop_s) begin
            count_s = count_r + CNT_W'(1);
        end else if (!push_s && pop_s) begin
            count_s = count_r - CNT_W'(1);
        end else begin
            count_s = count_r;
        end
    end

    // Next-state logic of the per-frame reset/launch/collect sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) state_s = ST_CORE_RST;
                else       state_s = ST_IDLE;
            end
            ST_CORE_RST: begin
                if (rst_cnt_r == RST_W'(RST_CYCLES - 1)) state_s = ST_LAUNCH;
                else                                      state_s = ST_CORE_RST;
            end
            ST_LAUNCH: state_s = ST_WAIT;
            ST_WAIT: begin
                if (core_output_ready) state_s = out_free_s ? ST_IDLE : ST_HOLD;
                else if (drop_s)       state_s = ST_IDLE;
                else                   state_s = ST_WAIT;
            end
            ST_HOLD: begin
                if (out_free_s) state_s = ST_IDLE;
                else            state_s = ST_HOLD;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register plus core strobes and status flags registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            core_reset       <= 1'b0;
            core_input_ready <= 1'b0;
            busy             <= 1'b0;
            in_ready         <= 1'b1;
        end else begin
            state_r          <= state_s;
            core_reset       <= (state_s == ST_CORE_RST);
            core_input_ready <= (state_s == ST_LAUNCH);
            busy             <= (state_s != ST_IDLE) || (count_s != CNT_W'(0));
            in_ready         <= (count_s != CNT_W'(DEPTH));
        end
    end

    // Frame FIFO storage, pointers, occupancy and push tag counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_r[i] <= '0;
                fifo_tag_r[i]  <= 8'd0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            push_tag_r <= 8'd0;
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= in_data;
                fifo_tag_r[wr_ptr_r]  <= push_tag_r;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
                push_tag_r            <= push_tag_r + 8'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_s;
        end
    end

    // Launch register and in-flight tag, plus the reset and wait cycle counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_input_data <= '0;
            cur_tag_r       <= 8'd0;
            rst_cnt_r       <= '0;
            wait_cnt_r      <= '0;
        end else begin
            if (pop_s) begin
                core_input_data <= fifo_data_r[rd_ptr_r];
                cur_tag_r       <= fifo_tag_r[rd_ptr_r];
                rst_cnt_r       <= '0;
            end else if (state_r == ST_CORE_RST) begin
                rst_cnt_r <= rst_cnt_r + RST_W'(1);
            end
            if (state_r == ST_LAUNCH) begin
                wait_cnt_r <= '0;
            end else if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end
        end
    end

    // Output register: capture the core result, hold it until downstream accepts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= 8'd0;
        end else if (capture_s) begin
            out_valid <= 1'b1;
            out_data  <= core_output_data;
            out_tag   <= cur_tag_r;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky timeout flag and saturating dropped-frame counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err <= 1'b0;
            drop_count  <= 8'd0;
        end else if (drop_s) begin
            timeout_err <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_jet_tag_scheduler.sv
// Directed bench for jet_tag_scheduler: a simple core model with configurable
// latency, a scoreboard of expected results in push order, and timing checks.
module tb_jet_tag_scheduler;

    localparam int WIDTH       = 16;
    localparam int INPUT_SIZE  = 16;
    localparam int OUTPUT_SIZE = 5;
    localparam int DEPTH       = 4;
    localparam int TIMEOUT     = 1023;
    localparam int IN_W        = WIDTH * INPUT_SIZE;
    localparam int OUT_W       = WIDTH * OUTPUT_SIZE;

    logic             clk, reset_n, in_valid, in_ready, core_reset, core_input_ready;
    logic [IN_W-1:0]  in_data, core_input_data;
    logic             core_output_ready, out_valid, out_ready, busy, timeout_err;
    logic [OUT_W-1:0] core_output_data, out_data;
    logic [7:0]       out_tag, drop_count;

    typedef struct {
        logic [7:0]       tag;
        logic [OUT_W-1:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         core_lat = 3;
    bit         core_hang = 1'b0;
    int         launch_cnt = 0;
    int         overlap_cnt = 0;
    int         extra_cnt = 0;
    logic [7:0] tb_tag;

    jet_tag_scheduler #(
        .WIDTH(WIDTH), .NFRAC(10), .INPUT_SIZE(INPUT_SIZE), .OUTPUT_SIZE(OUTPUT_SIZE),
        .DEPTH(DEPTH), .RST_CYCLES(2), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_reset(core_reset), .core_input_ready(core_input_ready),
        .core_input_data(core_input_data), .core_output_ready(core_output_ready),
        .core_output_data(core_output_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .busy(busy), .timeout_err(timeout_err), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [127:0] obs, input logic [127:0] req);
        n_checks++;
        if (obs === req) n_pass++;
        else $display("FAIL %s: observed 0x%0h required 0x%0h", name, obs, req);
    endtask

    function automatic logic [IN_W-1:0] make_frame(input int seed);
        logic [IN_W-1:0] f;
        for (int k = 0; k < INPUT_SIZE; k++)
            f[k*WIDTH +: WIDTH] = 16'(seed * 291 + k * 65 + 7);
        return f;
    endfunction

    // Behaviour of the bench's core: class score k = feature k + feature k+8.
    function automatic logic [OUT_W-1:0] core_fn(input logic [IN_W-1:0] f);
        logic [OUT_W-1:0] o;
        for (int k = 0; k < OUTPUT_SIZE; k++)
            o[k*WIDTH +: WIDTH] = f[k*WIDTH +: WIDTH] + f[(k+8)*WIDTH +: WIDTH];
        return o;
    endfunction

    // Core model: cleared by core_reset, answers core_lat cycles after the launch strobe.
    initial begin
        logic [IN_W-1:0] held;
        int cnt;
        cnt = -1;
        held = '0;
        core_output_ready = 1'b0;
        core_output_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (core_reset && core_input_ready) overlap_cnt++;
            if (!reset_n || core_reset) begin
                cnt = -1;
                core_output_ready = 1'b0;
            end else if (core_input_ready) begin
                held = core_input_data;
                cnt = core_lat;
                launch_cnt++;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !core_hang) begin
                    core_output_ready = 1'b1;
                    core_output_data = core_fn(held);
                end
            end
        end
    end

    // Scoreboard sink: every accepted result must match the oldest expected frame.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    extra_cnt++;
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("out_tag", out_tag, e.tag);
                    check_eq("out_data", out_data, e.data);
                end
            end
        end
    end

    // Presents a frame at a falling edge and returns one falling edge after acceptance.
    task automatic push_frame(input int seed, input bit want_out);
        logic [IN_W-1:0] f;
        int   guard;
        exp_t e;
        f = make_frame(seed);
        in_valid = 1'b1;
        in_data = f;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check_eq("push_wait", guard, 0);
        @(negedge clk);
        if (want_out) begin
            e.tag = tb_tag;
            e.data = core_fn(f);
            exp_q.push_back(e);
        end
        tb_tag = tb_tag + 8'd1;
    endtask

    task automatic wait_drain(input int limit);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < limit) begin
            @(negedge clk);
            guard++;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    task automatic wait_launch();
        int guard;
        guard = 0;
        while (!core_input_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq("launch_seen", core_input_ready, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, l0;
        logic prev_cor;
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; tb_tag = 8'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_core_reset", core_reset, 1'b0);
        check_eq("rst_core_input_ready", core_input_ready, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_drop_count", drop_count, 8'd0);
        check_eq("rst_out_data", out_data, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single frame, core latency 20
        core_lat = 20;
        push_frame(1, 1'b1);
        in_valid = 1'b0;
        check_eq("t2_core_reset_e0", core_reset, 1'b0);
        check_eq("t2_busy", busy, 1'b1);
        @(negedge clk);
        check_eq("t2_core_reset_e1", core_reset, 1'b1);
        check_eq("t2_cir_e1", core_input_ready, 1'b0);
        @(negedge clk);
        check_eq("t2_core_reset_e2", core_reset, 1'b1);
        @(negedge clk);
        check_eq("t2_core_reset_e3", core_reset, 1'b0);
        check_eq("t2_cir_e3", core_input_ready, 1'b1);
        @(negedge clk);
        check_eq("t2_cir_e4", core_input_ready, 1'b0);
        n = 0; prev_cor = 1'b0;
        while (!out_valid && n < 100) begin
            prev_cor = core_output_ready;
            @(negedge clk);
            n++;
        end
        check_eq("t2_out_valid", out_valid, 1'b1);
        check_eq("t2_cor_before_valid", prev_cor, 1'b1);
        check_eq("t2_result_latency", n, 20);
        wait_drain(10);

        // Five frames back-to-back; a sixth is offered while the FIFO is full
        core_lat = 3;
        l0 = launch_cnt;
        for (int i = 0; i < 5; i++) push_frame(10 + i, 1'b1);
        check_eq("t3_full_in_ready", in_ready, 1'b0);
        in_data = make_frame(99);
        @(negedge clk);
        check_eq("t3_full_in_ready2", in_ready, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_drain(300);
        check_eq("t3_launches", launch_cnt - l0, 5);
        @(negedge clk);
        check_eq("t3_busy_idle", busy, 1'b0);
        check_eq("t3_in_ready", in_ready, 1'b1);

        // Output back-pressure: second frame parks in HOLD
        out_ready = 1'b0;
        l0 = launch_cnt;
        push_frame(20, 1'b1);
        push_frame(21, 1'b1);
        push_frame(22, 1'b1);
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("t4_out_valid", out_valid, 1'b1);
        check_eq("t4_out_tag", out_tag, exp_q[0].tag);
        check_eq("t4_out_data", out_data, exp_q[0].data);
        check_eq("t4_core_reset", core_reset, 1'b0);
        check_eq("t4_busy", busy, 1'b1);
        check_eq("t4_launches_held", launch_cnt - l0, 2);
        out_ready = 1'b1;
        wait_drain(200);
        check_eq("t4_launches_done", launch_cnt - l0, 3);

        // Timeout: core never answers, frame dropped, next frame gets tag 1
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tb_tag = 8'd0;
        exp_q.delete();
        @(negedge clk);
        core_hang = 1'b1;
        push_frame(30, 1'b0);
        in_valid = 1'b0;
        wait_launch();
        n = 0;
        while (!timeout_err && n < TIMEOUT + 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("t5_timeout_cycles", n, TIMEOUT + 1);
        check_eq("t5_drop_count", drop_count, 8'd1);
        check_eq("t5_busy", busy, 1'b0);
        core_hang = 1'b0;
        core_lat = 5;
        push_frame(31, 1'b1);
        in_valid = 1'b0;
        wait_drain(100);
        check_eq("t5_err_sticky", timeout_err, 1'b1);
        check_eq("t5_drop_sticky", drop_count, 8'd1);

        // Reset three cycles into WAIT with two frames queued
        core_lat = 20;
        push_frame(40, 1'b1);
        push_frame(41, 1'b1);
        push_frame(42, 1'b1);
        in_valid = 1'b0;
        wait_launch();
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("t6_core_reset", core_reset, 1'b0);
        check_eq("t6_cir", core_input_ready, 1'b0);
        check_eq("t6_in_ready", in_ready, 1'b1);
        check_eq("t6_busy", busy, 1'b0);
        check_eq("t6_timeout_err", timeout_err, 1'b0);
        check_eq("t6_drop_count", drop_count, 8'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        tb_tag = 8'd0;
        l0 = launch_cnt;
        repeat (10) @(negedge clk);
        check_eq("t6_no_launch", launch_cnt - l0, 0);
        check_eq("t6_busy_after", busy, 1'b0);
        core_lat = 4;
        push_frame(50, 1'b1);
        in_valid = 1'b0;
        wait_drain(100);

        check_eq("no_launch_during_reset", overlap_cnt, 0);
        check_eq("no_unexpected_output", extra_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
